hazard_fwd_unit: RTL and testbench

- Parametrised pipeline-control block for the next-generation pipelined CPU.
- Tracks the destination register of every in-flight instruction behind decode (EXE, MEM, WB, ... up to STAGES deep).
- Generates per-operand forwarding selects, load-use stall and branch-flush bubbles, plus saturating stall/flush performance counters.
- Sits beside the ID stage. Its stage table advances in lockstep with the datapath's inter-stage registers.

---
 rtl/hazard_fwd_unit.sv | 117 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Pipeline-control block that sits beside the ID stage. It keeps a small
//   table describing the destination register of every instruction in flight
//   behind decode (index 0 = EXE, 1 = MEM, 2 = WB, ...). From that table and
//   the ID-stage operands it produces forwarding selects, a load-use stall,
//   and saturating stall/flush event counters. The table shifts in lockstep
//   with the datapath's inter-stage registers.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   id_*           decoded fields of the instruction currently in ID
//   flush          taken branch/jump in EXE: the ID instruction is killed
//   freeze         global hold: nothing in the table or counters moves
//   stall          hold PC and IF/ID this cycle (load-use hazard)
//   fwd_a, fwd_b   operand source: 0 = regfile, k+1 = result of stage k
//   stage_valid    valid bit of each tracked stage
//   stall_cnt      number of stall cycles, saturating
//   flush_cnt      number of flush events, saturating

module hazard_fwd_unit #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter int FW         = 2,
  parameter int CW         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              flush,
  input  logic              freeze,
  output logic              stall,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [STAGES-1:0] stage_valid,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wreg_q;
  logic [STAGES-1:0] m2reg_q;
  logic [REG_AW-1:0] rd_q [STAGES];

  logic load_a;
  logic load_b;
  logic hazard;

  // Walk the table from oldest to youngest so the youngest matching stage
  // overwrites any older match and wins. A load found at stage i is consumed
  // by the ID instruction once that instruction reaches EXE, by which time
  // the load sits at stage i+1; it is only a hazard while i+1 is still short
  // of LOAD_READY. This yields exactly LOAD_READY-1 stall cycles.
  always_comb begin
    fwd_a  = '0;
    fwd_b  = '0;
    load_a = 1'b0;
    load_b = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (valid_q[i] && wreg_q[i] && id_valid) begin
        if (id_use_rs && (id_rs != '0) && (rd_q[i] == id_rs)) begin
          fwd_a  = FW'(i + 1);
          load_a = m2reg_q[i] && ((i + 1) < LOAD_READY);
        end
        if (id_use_rt && (id_rt != '0) && (rd_q[i] == id_rt)) begin
          fwd_b  = FW'(i + 1);
          load_b = m2reg_q[i] && ((i + 1) < LOAD_READY);
        end
      end
    end
  end

  // A flush kills the dependent instruction anyway, so it overrides the stall.
  assign hazard      = load_a | load_b;
  assign stall       = hazard & ~flush;
  assign stage_valid = valid_q;

  // Table shift and counters. freeze holds everything, including counters;
  // when not frozen a stalled or flushed ID slot enters the table as a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      wreg_q    <= '0;
      m2reg_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        rd_q[i] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        wreg_q[i]  <= wreg_q[i-1];
        m2reg_q[i] <= m2reg_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
      valid_q[0] <= id_valid & ~stall & ~flush;
      wreg_q[0]  <= id_wreg;
      m2reg_q[0] <= id_m2reg;
      rd_q[0]    <= id_rd;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
//   Directed bench for hazard_fwd_unit (STAGES=3, LOAD_READY=2, CW=4).
//   Every step drives the ID inputs, pushes the outputs expected for that
//   cycle onto a queue, then pops and compares them mid-cycle before the
//   next rising edge updates the table.

module tb_hazard_fwd_unit;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_wreg;
  logic       id_m2reg;
  logic       flush;
  logic       freeze;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [2:0] stage_valid;
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct packed {
    logic [31:0] step;
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  sv;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t exp_q[$];

  hazard_fwd_unit #(
    .REG_AW(5), .STAGES(3), .LOAD_READY(2), .FW(2), .CW(4)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .flush(flush), .freeze(freeze), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard empty at step %0d", step_no);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (stall === e.stall) else begin
      failures++;
      $error("[TB] FAIL step%0d stall observed=%0b expected=%0b", e.step, stall, e.stall);
    end
    checks++;
    assert (fwd_a === e.fa) else begin
      failures++;
      $error("[TB] FAIL step%0d fwd_a observed=%0d expected=%0d", e.step, fwd_a, e.fa);
    end
    checks++;
    assert (fwd_b === e.fb) else begin
      failures++;
      $error("[TB] FAIL step%0d fwd_b observed=%0d expected=%0d", e.step, fwd_b, e.fb);
    end
    checks++;
    assert (stage_valid === e.sv) else begin
      failures++;
      $error("[TB] FAIL step%0d stage_valid observed=%b expected=%b", e.step, stage_valid, e.sv);
    end
    checks++;
    assert (stall_cnt === e.sc) else begin
      failures++;
      $error("[TB] FAIL step%0d stall_cnt observed=%0d expected=%0d", e.step, stall_cnt, e.sc);
    end
    checks++;
    assert (flush_cnt === e.fc) else begin
      failures++;
      $error("[TB] FAIL step%0d flush_cnt observed=%0d expected=%0d", e.step, flush_cnt, e.fc);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue what should be seen
  // before the next rising edge, then check it once the logic has settled.
  task automatic applyStimulus(
    input logic rst, input logic fz, input logic fl, input logic v,
    input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
    input logic [4:0] rd, input logic wr, input logic m2,
    input logic xs, input logic [1:0] xa, input logic [1:0] xb,
    input logic [2:0] xv, input logic [3:0] xsc, input logic [3:0] xfc);
    exp_t e;
    @(negedge clock);
    step_no++;
    reset     = rst;
    freeze    = fz;
    flush     = fl;
    id_valid  = v;
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
    id_rd     = rd;
    id_wreg   = wr;
    id_m2reg  = m2;
    e.step  = 32'(step_no);
    e.stall = xs;
    e.fa    = xa;
    e.fb    = xb;
    e.sv    = xv;
    e.sc    = xsc;
    e.fc    = xfc;
    exp_q.push_back(e);
    #2;
    checkOutput();
  endtask

  // Empty ID slot with no flush/freeze.
  task automatic idleStep(input logic [2:0] xv, input logic [3:0] xsc, input logic [3:0] xfc);
    applyStimulus(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, xv, xsc, xfc);
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rd = '0; id_wreg = 1'b0; id_m2reg = 1'b0;
    repeat (2) @(posedge clock);
    $display("[TB] reset released");

    // ALU back-to-back: add r3, reader of rs=r3, then reader of rt=r3.
    applyStimulus(0,0,0,1, 0,0,0,0, 3,1,0, 0,0,0, 3'b000, 0, 0);
    applyStimulus(0,0,0,1, 3,1,0,0, 6,1,0, 0,1,0, 3'b001, 0, 0);
    applyStimulus(0,0,0,1, 0,0,3,1, 0,0,0, 0,0,2, 3'b011, 0, 0);
    idleStep(3'b111, 0, 0);
    idleStep(3'b110, 0, 0);
    idleStep(3'b100, 0, 0);

    // Load-use: load r5 then reader of r5; one stall cycle, then fwd=2.
    applyStimulus(0,0,0,1, 0,0,0,0, 5,1,1, 0,0,0, 3'b000, 0, 0);
    applyStimulus(0,0,0,1, 5,1,0,0, 7,1,0, 1,1,0, 3'b001, 0, 0);
    applyStimulus(0,0,0,1, 5,1,0,0, 7,1,0, 0,2,0, 3'b010, 1, 0);
    idleStep(3'b101, 1, 0);
    idleStep(3'b010, 1, 0);
    idleStep(3'b100, 1, 0);

    // Priority and r0 handling.
    applyStimulus(0,0,0,1, 0,0,0,0, 4,1,0, 0,0,0, 3'b000, 1, 0);
    applyStimulus(0,0,0,1, 0,0,0,0, 4,1,0, 0,0,0, 3'b001, 1, 0);
    applyStimulus(0,0,0,1, 4,1,4,1, 0,0,0, 0,1,1, 3'b011, 1, 0);
    applyStimulus(0,0,0,1, 0,0,0,0, 0,1,0, 0,0,0, 3'b111, 1, 0);
    applyStimulus(0,0,0,1, 0,1,0,1, 0,0,0, 0,0,0, 3'b111, 1, 0);
    applyStimulus(0,0,0,1, 0,0,0,0, 9,1,0, 0,0,0, 3'b111, 1, 0);
    applyStimulus(0,0,0,1, 9,0,9,1, 0,0,0, 0,0,1, 3'b111, 1, 0);
    applyStimulus(0,0,0,0, 9,1,0,0, 0,0,0, 0,0,0, 3'b111, 1, 0);
    idleStep(3'b110, 1, 0);
    idleStep(3'b100, 1, 0);

    // Flush during a load-use hazard: no stall, bubble, flush counted.
    applyStimulus(0,0,0,1, 0,0,0,0, 5,1,1, 0,0,0, 3'b000, 1, 0);
    applyStimulus(0,0,1,1, 5,1,0,0, 8,1,0, 0,1,0, 3'b001, 1, 0);
    idleStep(3'b010, 1, 1);
    idleStep(3'b100, 1, 1);

    // Freeze with flush pulses: table and counters hold, then advance.
    applyStimulus(0,0,0,1, 0,0,0,0, 7,1,0, 0,0,0, 3'b000, 1, 1);
    applyStimulus(0,1,1,1, 7,1,0,0, 0,0,0, 0,1,0, 3'b001, 1, 1);
    applyStimulus(0,1,0,0, 0,0,0,0, 0,0,0, 0,0,0, 3'b001, 1, 1);
    applyStimulus(0,1,1,0, 0,0,0,0, 0,0,0, 0,0,0, 3'b001, 1, 1);
    idleStep(3'b001, 1, 1);
    idleStep(3'b010, 1, 1);
    idleStep(3'b100, 1, 1);

    // Saturation: chained loads of r5 reading r5 stall every other cycle.
    // A frozen stall cycle first shows stall=1 without counting.
    applyStimulus(0,0,0,1, 0,0,0,0, 5,1,1, 0,0,0, 3'b000, 1, 1);
    applyStimulus(0,1,0,1, 5,1,0,0, 5,1,1, 1,1,0, 3'b001, 1, 1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0,0,0,1, 5,1,0,0, 5,1,1, 1,1,0,
                    (k == 0) ? 3'b001 : 3'b101, sat4(1 + k), 1);
      applyStimulus(0,0,0,1, 5,1,0,0, 5,1,1, 0,2,0, 3'b010, sat4(2 + k), 1);
    end

    // Reset clears the table and both counters; counting restarts from 0.
    applyStimulus(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 3'b101, 15, 1);
    applyStimulus(0,0,0,1, 5,1,0,0, 5,1,1, 0,0,0, 3'b000, 0, 0);
    applyStimulus(0,0,0,1, 5,1,0,0, 0,0,0, 1,1,0, 3'b001, 0, 0);
    idleStep(3'b010, 1, 0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard leftover entries=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
